duty_ramp_ctrl: RTL and testbench

Upstream duty-cycle source for the board's variable-duty clock divider. Produces the 8-bit `duty_percentage` word (0..100) consumed by the divider. In manual mode the word is stepped by debounced push-buttons. In breathe mode it ramps 0 -> 100 -> 0 continuously at a programmable step rate, giving an LED "breathing" effect on the divider output.

---
 rtl/duty_ramp_ctrl.sv | 148 ++++++++++++++
 tb/tb_duty_ramp_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle word source for the variable-duty clock divider: button-stepped
// manual mode, or a continuous 0 -> 100 -> 0 "breathe" ramp at step_hz.
module duty_ramp_ctrl #(
  parameter logic [27:0] clk_freq    = 28'd100_000000,
  parameter logic [27:0] step_hz     = 28'd100,
  parameter logic [7:0]  manual_step = 8'd10,
  parameter logic [7:0]  init_duty   = 8'd50
) (
  input  logic       sys_clk_in,
  input  logic       reset,
  input  logic       mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       hold,
  output logic [7:0] duty_percentage,
  output logic       ramp_dir,
  output logic       at_limit,
  output logic       step_tick
);

  localparam logic [27:0] TICK_COUNT = clk_freq / step_hz;
  localparam logic [7:0]  INIT_DUTY  = (init_duty > 8'd100) ? 8'd100 : init_duty;
  localparam logic [8:0]  DUTY_MAX   = 9'd100;

  typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DOWN} state_t;

  state_t      r_state;
  logic [27:0] r_count;
  logic        r_stepTick;
  logic        r_btnUpPrev;
  logic        r_btnDownPrev;
  logic [7:0]  r_duty;
  logic        r_rampDir;

  logic [27:0] w_countNext;
  logic        w_upEdge;
  logic        w_downEdge;
  logic [7:0]  w_manInc;
  logic [7:0]  w_manDec;
  logic [7:0]  w_rampInc;
  logic [7:0]  w_rampDec;

  // Arithmetic is done 9 bits wide so overflow/borrow is visible before clamping.
  function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > DUTY_MAX) ? 8'd100 : s[7:0];
  endfunction

  function automatic logic [7:0] satSub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[8])
      return 8'd0;
    return (d > DUTY_MAX) ? 8'd100 : d[7:0];
  endfunction

  assign w_countNext = (r_count >= TICK_COUNT) ? 28'd1 : r_count + 28'd1;
  assign w_upEdge    = btn_up & ~r_btnUpPrev;
  assign w_downEdge  = btn_down & ~r_btnDownPrev;
  assign w_manInc    = satAdd(r_duty, manual_step);
  assign w_manDec    = satSub(r_duty, manual_step);
  assign w_rampInc   = satAdd(r_duty, 8'd1);
  assign w_rampDec   = satSub(r_duty, 8'd1);

  // The tick is registered against the next count so it lines up with count == TICK_COUNT
  // yet stays low while reset is asserted, even when TICK_COUNT is 1.
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      r_count    <= 28'd1;
      r_stepTick <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_stepTick <= (w_countNext == TICK_COUNT);
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      r_btnUpPrev   <= 1'b1;
      r_btnDownPrev <= 1'b1;
    end else begin
      r_btnUpPrev   <= btn_up;
      r_btnDownPrev <= btn_down;
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      r_state   <= MANUAL;
      r_duty    <= INIT_DUTY;
      r_rampDir <= 1'b0;
    end else begin
      case (r_state)
        MANUAL: begin
          if (mode) begin
            if (r_duty < 8'd100) begin
              r_state   <= RAMP_UP;
              r_rampDir <= 1'b1;
            end else begin
              r_state   <= RAMP_DOWN;
              r_rampDir <= 1'b0;
            end
          end else if (w_upEdge && !w_downEdge) begin
            r_duty <= w_manInc;
          end else if (w_downEdge && !w_upEdge) begin
            r_duty <= w_manDec;
          end
        end
        // Leaving breathe mode wins over a coincident tick.
        RAMP_UP: begin
          if (!mode) begin
            r_state   <= MANUAL;
            r_rampDir <= 1'b0;
          end else if (r_stepTick && !hold) begin
            r_duty <= w_rampInc;
            if (w_rampInc == 8'd100) begin
              r_state   <= RAMP_DOWN;
              r_rampDir <= 1'b0;
            end
          end
        end
        RAMP_DOWN: begin
          if (!mode) begin
            r_state   <= MANUAL;
            r_rampDir <= 1'b0;
          end else if (r_stepTick && !hold) begin
            r_duty <= w_rampDec;
            if (w_rampDec == 8'd0) begin
              r_state   <= RAMP_UP;
              r_rampDir <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= MANUAL;
          r_rampDir <= 1'b0;
        end
      endcase
    end
  end

  assign duty_percentage = r_duty;
  assign ramp_dir        = r_rampDir;
  assign at_limit        = (r_duty == 8'd0) || (r_duty == 8'd100);
  assign step_tick       = r_stepTick;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed scoreboard bench for duty_ramp_ctrl with a 10-cycle step period;
// a second instance covers init_duty clamping.
module tb_duty_ramp_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       btnUp;
  logic       btnDown;
  logic       hold;
  logic [7:0] duty;
  logic       rampDir;
  logic       atLimit;
  logic       stepTick;
  logic [7:0] dutyClamp;
  logic       rampDirClamp;
  logic       atLimitClamp;
  logic       stepTickClamp;

  int    assertCount = 0;
  int    failCount   = 0;
  string expTag[$];
  int    expVal[$];

  always #5 clock = ~clock;

  duty_ramp_ctrl #(
    .clk_freq(28'd1000), .step_hz(28'd100), .manual_step(8'd10), .init_duty(8'd50)
  ) dut (
    .sys_clk_in(clock), .reset(reset), .mode(mode), .btn_up(btnUp), .btn_down(btnDown),
    .hold(hold), .duty_percentage(duty), .ramp_dir(rampDir), .at_limit(atLimit),
    .step_tick(stepTick)
  );

  duty_ramp_ctrl #(
    .clk_freq(28'd1000), .step_hz(28'd100), .manual_step(8'd10), .init_duty(8'd150)
  ) dutClamp (
    .sys_clk_in(clock), .reset(reset), .mode(mode), .btn_up(btnUp), .btn_down(btnDown),
    .hold(hold), .duty_percentage(dutyClamp), .ramp_dir(rampDirClamp),
    .at_limit(atLimitClamp), .step_tick(stepTickClamp)
  );

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic md, input logic hd);
    btnUp   = up;
    btnDown = down;
    mode    = md;
    hold    = hd;
  endtask

  task automatic pushExp(input string tag, input int value);
    expTag.push_back(tag);
    expVal.push_back(value);
  endtask

  task automatic checkOutput(input int observed);
    string tag;
    int    expected;
    assertCount++;
    if (expVal.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard: observed %0d with no expected value queued", observed);
    end else begin
      tag      = expTag.pop_front();
      expected = expVal.pop_front();
      assert (observed === expected) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
    end
  endtask

  task automatic checkNow(input string tag, input int expected, input int observed);
    pushExp(tag, expected);
    checkOutput(observed);
  endtask

  task automatic waitTick(input string tag);
    int n;
    n = 0;
    while (stepTick !== 1'b1 && n < 50) begin
      stepCycle();
      n++;
    end
    if (stepTick !== 1'b1) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s: step_tick observed 0 expected 1 within 50 cycles", tag);
    end
  endtask

  task automatic rampStep(input string tag, input int expDuty);
    pushExp(tag, expDuty);
    waitTick(tag);
    stepCycle();
    checkOutput(int'(duty));
  endtask

  task automatic pressButton(input string tag, input logic up, input logic down, input int expDuty);
    pushExp(tag, expDuty);
    applyStimulus(up, down, 1'b0, 1'b0);
    stepCycle();
    checkOutput(int'(duty));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
  endtask

  task automatic countToTick(output int edges);
    edges = 0;
    while (stepTick !== 1'b1 && edges < 50) begin
      stepCycle();
      edges++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int upSeq[6];
    upSeq = '{60, 70, 80, 90, 100, 100};

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkNow("rstDuty", 50, int'(duty));
    checkNow("rstRampDir", 0, int'(rampDir));
    checkNow("rstAtLimit", 0, int'(atLimit));
    checkNow("rstTick", 0, int'(stepTick));
    checkNow("clampDuty", 100, int'(dutyClamp));
    checkNow("clampAtLimit", 1, int'(atLimitClamp));

    reset = 1'b1;
    pushExp("firstTickEdges", 9);
    countToTick(n);
    checkOutput(n);

    for (int i = 0; i < 6; i++) pressButton("manualUp", 1'b1, 1'b0, upSeq[i]);
    checkNow("atLimitHigh", 1, int'(atLimit));
    for (int i = 1; i <= 11; i++) pressButton("manualDown", 1'b0, 1'b1, (100 - 10 * i < 0) ? 0 : 100 - 10 * i);
    checkNow("atLimitLow", 1, int'(atLimit));

    pushExp("upHeld1000", 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (1000) stepCycle();
    checkOutput(int'(duty));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();

    pressButton("toForty", 1'b1, 1'b0, 20);
    pressButton("toForty", 1'b1, 1'b0, 30);
    pressButton("toForty", 1'b1, 1'b0, 40);
    pressButton("bothButtons", 1'b1, 1'b1, 40);

    pushExp("modeEntryDuty", 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput(int'(duty));
    checkNow("modeEntryDir", 1, int'(rampDir));
    for (int v = 41; v <= 98; v++) rampStep("rampUp", v);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkNow("exitAt98Duty", 98, int'(duty));
    checkNow("exitAt98Dir", 0, int'(rampDir));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkNow("reenterDir", 1, int'(rampDir));
    rampStep("rampTo99", 99);
    checkNow("dirAt99", 1, int'(rampDir));
    rampStep("rampTo100", 100);
    checkNow("dirAt100", 0, int'(rampDir));
    checkNow("atLimit100", 1, int'(atLimit));

    waitTick("periodStart");
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (stepTick !== 1'b1 && n < 50);
    checkNow("tickPeriod", 10, n);
    checkNow("reverseTo99", 99, int'(duty));
    pushExp("reverseTo98", 98);
    stepCycle();
    checkOutput(int'(duty));
    for (int v = 97; v >= 0; v--) rampStep("rampDown", v);
    checkNow("dirAt0", 1, int'(rampDir));
    checkNow("atLimit0", 1, int'(atLimit));
    for (int v = 1; v <= 37; v++) rampStep("rampUpAgain", v);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pushExp("holdDuty", 37);
      waitTick("holdTick");
      stepCycle();
      checkOutput(int'(duty));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    rampStep("holdRelease", 38);

    waitTick("exitTick");
    pushExp("exitOnTickDuty", 38);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput(int'(duty));
    checkNow("exitOnTickDir", 0, int'(rampDir));
    pressButton("manualAfterExit", 1'b1, 1'b0, 48);

    for (int v = 58; v <= 98; v += 10) pressButton("toHundred", 1'b1, 1'b0, v);
    pressButton("toHundred", 1'b1, 1'b0, 100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkNow("entryAt100Dir", 0, int'(rampDir));
    for (int v = 99; v >= 63; v--) rampStep("rampDownTo63", v);

    reset = 1'b0;
    #1;
    checkNow("midRstDuty", 50, int'(duty));
    checkNow("midRstDir", 0, int'(rampDir));
    checkNow("midRstTick", 0, int'(stepTick));
    checkNow("midRstAtLimit", 0, int'(atLimit));
    stepCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pushExp("midRstFirstTick", 9);
    countToTick(n);
    checkOutput(n);
    pressButton("manualAfterReset", 1'b1, 1'b0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
